// File: rtl/md_pad_pkg.sv
// Shared constants for the Mega Drive pad responder: button and pin
// indices, the phases with special meaning in the 6-button read sequence,
// the output column selector and the default idle timeout for clk_sys.
package md_pad_pkg;

    // Button bit positions in the merged, active-high joystick word
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;

    // DB9 pin positions inside pad_out
    localparam int PIN1 = 0;
    localparam int PIN2 = 1;
    localparam int PIN3 = 2;
    localparam int PIN4 = 3;
    localparam int PIN6 = 4;
    localparam int PIN9 = 5;

    // Phases of the read sequence that change the returned data
    localparam logic [2:0] PH_ID  = 3'd5;
    localparam logic [2:0] PH_XYZ = 3'd6;
    localparam logic [2:0] PH_REL = 3'd7;

    // 1.5 ms of select inactivity at 48 MHz
    localparam int TIMEOUT_48MHZ = 72000;

    // Which set of pin levels the pad presents
    typedef enum logic [2:0] {
        COL_DIR,  // TH high: directions, B, C
        COL_XYZ,  // TH high, 6-button extra column: Z, Y, X, Mode, B, C
        COL_LOW,  // TH low: Up, Down, pins 3/4 low, A, Start
        COL_ID,   // TH low, 6-button identification: pins 1..4 low
        COL_REL   // TH low, sequence release: pins 1..4 high
    } col_e;

endpackage

// File: rtl/md_sel_sync.sv
// Brings the host's TH select line into clk_sys and flags every change of
// the synchronised level. All flops reset high to match an idle host.
module md_sel_sync
    import md_pad_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic sel_in,
    output logic sel_s,
    output logic sel_edge
);

    logic sel_p0;
    logic sel_p1;
    logic sel_prev;

    // Two-stage synchroniser followed by a history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_p0   <= 1'b1;
            sel_p1   <= 1'b1;
            sel_prev <= 1'b1;
        end else begin
            sel_p0   <= sel_in;
            sel_p1   <= sel_p0;
            sel_prev <= sel_p1;
        end
    end

    assign sel_s    = sel_p1;
    assign sel_edge = sel_p1 ^ sel_prev;

endmodule

// File: rtl/md6_pad_responder.sv
// Device-side Mega Drive 3/6-button pad. Follows the host's TH toggling
// through the 8-phase read sequence, restarts the sequence after a period of
// select inactivity, and drives registered active-low pin levels.
module md6_pad_responder
    import md_pad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_48MHZ,
    parameter int TO_W           = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        six_btn_en,
    input  logic        pad_sel,
    input  logic [11:0] buttons,
    output logic [5:0]  pad_out,
    output logic [2:0]  phase
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic            sel_s;
    logic            sel_edge;
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
    logic [2:0]      phase_base;
    logic [2:0]      phase_nxt;
    col_e            col;
    logic [5:0]      pad_nxt;

    // Active-low pin levels for one column of the pad
    function automatic logic [5:0] pins_for(input col_e c, input logic [11:0] b);
        logic [5:0] p;
        p = '1;
        case (c)
            COL_DIR: begin
                p[PIN1] = ~b[BTN_UP];
                p[PIN2] = ~b[BTN_DOWN];
                p[PIN3] = ~b[BTN_LEFT];
                p[PIN4] = ~b[BTN_RIGHT];
                p[PIN6] = ~b[BTN_B];
                p[PIN9] = ~b[BTN_C];
            end
            COL_XYZ: begin
                p[PIN1] = ~b[BTN_Z];
                p[PIN2] = ~b[BTN_Y];
                p[PIN3] = ~b[BTN_X];
                p[PIN4] = ~b[BTN_MODE];
                p[PIN6] = ~b[BTN_B];
                p[PIN9] = ~b[BTN_C];
            end
            COL_LOW: begin
                p[PIN1] = ~b[BTN_UP];
                p[PIN2] = ~b[BTN_DOWN];
                p[PIN3] = 1'b0;
                p[PIN4] = 1'b0;
                p[PIN6] = ~b[BTN_A];
                p[PIN9] = ~b[BTN_START];
            end
            COL_ID: begin
                p[PIN1] = 1'b0;
                p[PIN2] = 1'b0;
                p[PIN3] = 1'b0;
                p[PIN4] = 1'b0;
                p[PIN6] = ~b[BTN_A];
                p[PIN9] = ~b[BTN_START];
            end
            COL_REL: begin
                p[PIN1] = 1'b1;
                p[PIN2] = 1'b1;
                p[PIN3] = 1'b1;
                p[PIN4] = 1'b1;
                p[PIN6] = ~b[BTN_A];
                p[PIN9] = ~b[BTN_START];
            end
            default: p = '1;
        endcase
        return p;
    endfunction

    md_sel_sync u_sel_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel_in   (pad_sel),
        .sel_s    (sel_s),
        .sel_edge (sel_edge)
    );

    // Expiry restarts the sequence first, so an edge on that same cycle
    // still counts and lands on phase 1.
    assign timed_out  = (to_cnt == TO_MAX);
    assign phase_base = timed_out ? 3'd0 : phase;
    assign phase_nxt  = phase_base + {2'b00, sel_edge};

    // Phase counter and saturating inactivity timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 3'd0;
            to_cnt <= TO_MAX;
        end else begin
            phase <= phase_nxt;
            if (sel_edge) begin
                to_cnt <= '0;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Column choice follows the TH level itself; the phase only picks the
    // special 6-button columns, so a glitching host still sees 3-button data.
    // The upcoming phase is used so level and phase land in pad_out together.
    always_comb begin
        col = COL_DIR;
        if (sel_s) begin
            if (six_btn_en && phase_nxt == PH_XYZ) col = COL_XYZ;
            else                                   col = COL_DIR;
        end else begin
            if (six_btn_en && phase_nxt == PH_ID)       col = COL_ID;
            else if (six_btn_en && phase_nxt == PH_REL) col = COL_REL;
            else                                        col = COL_LOW;
        end
        pad_nxt = pins_for(col, buttons);
    end

    // Registered pin levels, all released while in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_out <= 6'b111111;
        end else begin
            pad_out <= pad_nxt;
        end
    end

endmodule

// File: tb/tb_md6_pad_responder.sv
// Bench for md6_pad_responder: table of steady-state vectors plus hand-written
// sequences for latency, the 6-button cycle, timeout and reset.
module tb_md6_pad_responder;

    localparam int TO = 100;

    logic        clk;
    logic        reset_n;
    logic        six_btn_en;
    logic        pad_sel;
    logic [11:0] buttons;
    logic [5:0]  pad_out;
    logic [2:0]  phase;

    int checks;
    int failures;

    typedef struct {
        logic        sel;
        logic        six;
        logic [11:0] btn;
        logic [5:0]  pad;
        logic [2:0]  ph;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] pad;
        logic [2:0] ph;
    } exp_t;

    vec_t       tbl [8];
    exp_t       sb [$];
    logic [5:0] exp6 [7];
    logic [5:0] exp3 [7];

    md6_pad_responder #(
        .TIMEOUT_CYCLES (TO),
        .TO_W           (17)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .six_btn_en (six_btn_en),
        .pad_sel    (pad_sel),
        .buttons    (buttons),
        .pad_out    (pad_out),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input logic [5:0] pd, input logic [2:0] ph);
        exp_t e;
        e.name = nm;
        e.pad  = pd;
        e.ph   = ph;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (pad_out !== e.pad || phase !== e.ph) begin
            failures++;
            $display("FAIL %s: got pad_out=%b phase=%0d, expected pad_out=%b phase=%0d",
                     e.name, pad_out, phase, e.pad, e.ph);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_sel();
        @(negedge clk);
        pad_sel = ~pad_sel;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pad_sel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clk_n(3);
    endtask

    task automatic run_seq(input logic six);
        do_reset();
        six_btn_en = six;
        buttons    = 12'h900;
        for (int i = 1; i <= 7; i++) begin
            toggle_sel();
            push_exp($sformatf("seq_six%0d_ph%0d", six, i), six ? exp6[i-1] : exp3[i-1], 3'(i));
            clk_n(20);
            check_front();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        six_btn_en = 1'b0;
        pad_sel    = 1'b1;
        buttons    = 12'h000;

        tbl[0] = '{1'b1, 1'b0, 12'h00F, 6'b110000, 3'd0};
        tbl[1] = '{1'b0, 1'b0, 12'h0C0, 6'b000011, 3'd1};
        tbl[2] = '{1'b0, 1'b0, 12'h000, 6'b110011, 3'd1};
        tbl[3] = '{1'b1, 1'b0, 12'h030, 6'b001111, 3'd2};
        tbl[4] = '{1'b1, 1'b0, 12'h005, 6'b110101, 3'd2};
        tbl[5] = '{1'b0, 1'b0, 12'h00A, 6'b110010, 3'd3};
        tbl[6] = '{1'b0, 1'b0, 12'hFFF, 6'b000000, 3'd3};
        tbl[7] = '{1'b1, 1'b0, 12'hF00, 6'b111111, 3'd4};

        exp6[0] = 6'b110011; exp6[1] = 6'b111111; exp6[2] = 6'b110011;
        exp6[3] = 6'b111111; exp6[4] = 6'b110000; exp6[5] = 6'b110110;
        exp6[6] = 6'b111111;
        exp3[0] = 6'b110011; exp3[1] = 6'b111111; exp3[2] = 6'b110011;
        exp3[3] = 6'b111111; exp3[4] = 6'b110011; exp3[5] = 6'b111111;
        exp3[6] = 6'b110011;

        // Reset state
        #12;
        push_exp("reset_state", 6'b111111, 3'd0);
        check_front();
        @(negedge clk);
        reset_n = 1'b1;
        clk_n(3);
        push_exp("idle_after_reset", 6'b111111, 3'd0);
        check_front();

        // Steady-state 3-button vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pad_sel    = tbl[i].sel;
            six_btn_en = tbl[i].six;
            buttons    = tbl[i].btn;
            push_exp($sformatf("vec%0d", i), tbl[i].pad, tbl[i].ph);
            clk_n(20);
            check_front();
        end

        // Select-to-output latency and button-to-output latency
        do_reset();
        six_btn_en = 1'b0;
        buttons    = 12'h0C0;
        clk_n(2);
        toggle_sel();
        clk_n(2);
        push_exp("sel_lat_2clk", 6'b111111, 3'd0);
        check_front();
        clk_n(1);
        push_exp("sel_lat_3clk", 6'b000011, 3'd1);
        check_front();
        @(negedge clk);
        buttons = 12'h000;
        #1;
        push_exp("btn_lat_0clk", 6'b000011, 3'd1);
        check_front();
        clk_n(1);
        push_exp("btn_lat_1clk", 6'b110011, 3'd1);
        check_front();

        // Full read sequence in 6-button and 3-button mode
        run_seq(1'b1);
        run_seq(1'b0);

        // Timeout after phase 3, then next edge gives 3-button data
        do_reset();
        six_btn_en = 1'b1;
        buttons    = 12'h000;
        toggle_sel();
        clk_n(20);
        toggle_sel();
        clk_n(20);
        toggle_sel();
        repeat (TO + 2) @(posedge clk);
        #1;
        push_exp("timeout_minus1", 6'b110011, 3'd3);
        check_front();
        clk_n(1);
        push_exp("timeout_exact", 6'b110011, 3'd0);
        check_front();
        @(negedge clk);
        buttons = 12'h400;
        toggle_sel();
        clk_n(5);
        push_exp("after_timeout_edge", 6'b111111, 3'd1);
        check_front();

        // Edge landing on the expiry cycle
        do_reset();
        six_btn_en = 1'b1;
        buttons    = 12'h000;
        toggle_sel();
        clk_n(20);
        toggle_sel();
        clk_n(20);
        toggle_sel();
        repeat (TO) @(posedge clk);
        toggle_sel();
        clk_n(3);
        push_exp("edge_on_expiry", 6'b111111, 3'd1);
        check_front();

        // Asynchronous reset at phase 6
        do_reset();
        six_btn_en = 1'b1;
        buttons    = 12'h900;
        for (int i = 0; i < 6; i++) begin
            toggle_sel();
            clk_n(20);
        end
        push_exp("pre_reset_ph6", 6'b110110, 3'd6);
        check_front();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push_exp("async_reset", 6'b111111, 3'd0);
        check_front();
        @(negedge clk);
        reset_n = 1'b1;
        clk_n(3);
        push_exp("reset_release", 6'b111111, 3'd0);
        check_front();
        toggle_sel();
        clk_n(5);
        push_exp("restart_ph1", 6'b110011, 3'd1);
        check_front();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
